// File: rtl/fetch_predict.sv
// Two-stage instruction fetch (F1 address, F2 predecode) feeding decode.
// Define GSHARE_EN for the trained gshare predictor; otherwise prediction is static BTFN.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_pc,
    input  logic [7:0]  resolve_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        prediction,
    output logic [7:0]  pc_xor_global_history
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]        fetch_pc_p0;
    logic [31:0]        pc_p1;
    logic               vld_p1;

    logic               is_branch;
    logic               is_jal;
    logic               br_taken;
    logic               pred_taken;
    logic [7:0]         index;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic [31:0]        target;

    // While stalled, re-read the word already sitting in F2 so imem_data stays put.
    assign imem_addr = stall ? pc_p1 : fetch_pc_p0;

    // ---- F2: predecode of imem_data, which belongs to pc_p1 ----
    always_comb begin
        is_branch = (imem_data[6:0] == OP_BRANCH);
        is_jal    = (imem_data[6:0] == OP_JAL);
        imm_b     = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25],
                     imem_data[11:8], 1'b0};
        imm_j     = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20],
                     imem_data[30:21], 1'b0};
        target    = pc_p1 + (is_jal ? imm_j : imm_b);
    end

    assign pred_taken = vld_p1 && (is_jal || (is_branch && br_taken));

`ifdef GSHARE_EN
    logic [7:0] ghr;
    logic [1:0] pht [256];
    logic       unused_resolve;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign index          = pc_p1[9:2] ^ ghr;
    assign br_taken       = pht[index][1];
    assign unused_resolve = ^{resolve_pc[31:9], resolve_pc[1:0]};

    // Training is independent of stall; a same-cycle read sees the old counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < 256; i++) begin
                pht[i] <= 2'b01;
            end
        end else begin
            if (resolve_valid) begin
                pht[resolve_index] <= sat_update(pht[resolve_index], resolve_taken);
            end
            if (redirect) begin
                if (resolve_valid) begin
                    ghr <= {resolve_index[6:0] ^ resolve_pc[8:2], resolve_taken};
                end
            end else if (!stall && vld_p1 && is_branch) begin
                ghr <= {ghr[6:0], br_taken};
            end
        end
    end
`else
    logic unused_resolve;

    assign index          = pc_p1[9:2];
    assign br_taken       = imm_b[31];
    assign unused_resolve = ^{resolve_valid, resolve_taken, resolve_pc, resolve_index};
`endif

    // ---- F1: fetch address and the F1->F2 address register ----
    always_ff @(posedge clk) begin
        if (redirect || !stall) begin
            pc_p1 <= fetch_pc_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_p0 <= RESET_PC;
            vld_p1      <= 1'b0;
        end else if (redirect) begin
            fetch_pc_p0 <= redirect_pc;
            vld_p1      <= 1'b0;
        end else if (!stall) begin
            fetch_pc_p0 <= pred_taken ? target : fetch_pc_p0 + 32'd4;
            vld_p1      <= !pred_taken;
        end
    end

    // ---- F2 -> decode output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid                 <= 1'b0;
            pc                    <= '0;
            instr                 <= NOP;
            prediction            <= 1'b0;
            pc_xor_global_history <= '0;
        end else if (redirect) begin
            valid                 <= 1'b0;
            pc                    <= pc_p1;
            instr                 <= NOP;
            prediction            <= 1'b0;
            pc_xor_global_history <= index;
        end else if (!stall) begin
            valid                 <= vld_p1;
            pc                    <= pc_p1;
            instr                 <= vld_p1 ? imem_data : NOP;
            prediction            <= pred_taken;
            pc_xor_global_history <= index;
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed scenarios then randomized traffic against a stream-level model.
module tb_fetch_predict;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOPW   = 32'h0000_0013;
`ifdef GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_pc;
    logic [7:0]  resolve_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        prediction;
    logic [7:0]  pc_xor_global_history;

    logic [31:0] prog [256];
    int          checks = 0;
    int          errors = 0;

    fetch_predict #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
        .resolve_index(resolve_index), .imem_addr(imem_addr),
        .imem_data(imem_data), .valid(valid), .pc(pc), .instr(instr),
        .prediction(prediction), .pc_xor_global_history(pc_xor_global_history)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction BRAM
    always @(posedge clk) imem_data <= prog[imem_addr[9:2]];

    // Model: stream of words decode should see
    logic [31:0] m_next_pc;
    int          m_bubbles;
    int          m_ghr;
    int          m_pht [256];
    logic        e_valid;
    logic        e_pred;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [7:0]  e_idx;

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'd0, 5'd0, 3'd0, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] o;
        o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic int b_off(input logic [31:0] w);
        int v;
        v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
        return (v >= 4096) ? v - 8192 : v;
    endfunction

    function automatic int j_off(input logic [31:0] w);
        int v;
        v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
        return (v >= 1048576) ? v - 2097152 : v;
    endfunction

    task automatic model_edge();
        logic [31:0] w;
        logic [31:0] tgt;
        int          idx;
        bit          taken;
        if (rst) begin
            m_next_pc = RST_PC;
            m_bubbles = 1;
            m_ghr     = 0;
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            e_valid = 1'b0; e_pc = '0; e_instr = NOPW; e_pred = 1'b0; e_idx = '0;
            return;
        end
        if (redirect) begin
            e_valid = 1'b0; e_instr = NOPW; e_pred = 1'b0;
            m_next_pc = redirect_pc;
            m_bubbles = 1;
            if (GS && resolve_valid)
                m_ghr = (((int'(resolve_index) ^ int'((resolve_pc >> 2) & 32'hFF)) * 2)
                         + int'(resolve_taken)) % 256;
        end else if (!stall) begin
            if (m_bubbles > 0) begin
                e_valid = 1'b0; e_instr = NOPW; e_pred = 1'b0;
                m_bubbles--;
            end else begin
                w     = prog[(m_next_pc / 4) % 256];
                idx   = int'((m_next_pc / 4) % 256);
                if (GS) idx = idx ^ m_ghr;
                taken = 1'b0;
                tgt   = m_next_pc + 32'd4;
                if (w[6:0] == 7'b1101111) begin
                    taken = 1'b1;
                    tgt   = m_next_pc + 32'(j_off(w));
                end else if (w[6:0] == 7'b1100011) begin
                    taken = GS ? (m_pht[idx] >= 2) : (b_off(w) < 0);
                    if (taken) tgt = m_next_pc + 32'(b_off(w));
                    if (GS) m_ghr = (m_ghr * 2 + int'(taken)) % 256;
                end
                e_valid = 1'b1; e_pc = m_next_pc; e_instr = w; e_pred = taken; e_idx = 8'(idx);
                m_next_pc = tgt;
                m_bubbles = taken ? 1 : 0;
            end
        end
        if (GS && resolve_valid) begin
            if (resolve_taken) m_pht[resolve_index] = (m_pht[resolve_index] == 3) ? 3 : m_pht[resolve_index] + 1;
            else               m_pht[resolve_index] = (m_pht[resolve_index] == 0) ? 0 : m_pht[resolve_index] - 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("valid", 32'(valid), 32'(e_valid));
        check("instr", instr, e_instr);
        check("prediction", 32'(prediction), 32'(e_pred));
        if (e_valid) begin
            check("pc", pc, e_pc);
            check("pc_xor_global_history", 32'(pc_xor_global_history), 32'(e_idx));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic rv, input logic rt,
                               input logic [31:0] rpc, input logic [7:0] ri);
        redirect = 1'b1; redirect_pc = tgt;
        resolve_valid = rv; resolve_taken = rt; resolve_pc = rpc; resolve_index = ri;
        step();
        redirect = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    endtask

    task automatic resolve_step(input logic rt, input logic [7:0] ri, input logic [31:0] rpc);
        resolve_valid = 1'b1; resolve_taken = rt; resolve_index = ri; resolve_pc = rpc;
        step();
        resolve_valid = 1'b0; resolve_taken = 1'b0;
    endtask

    initial begin
        int r;
        int off;
        for (int i = 0; i < 256; i++) prog[i] = NOPW | (32'(i) << 20);
        prog[8'h80] = enc_b(-16);
        prog[8'hC0] = enc_j(32'h20);
        prog[8'h07] = enc_b(8);

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_pc = '0; resolve_index = '0;

        // reset state and first words after release
        run(2);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_pc", pc, 32'h0);
        check("rst_pcx", 32'(pc_xor_global_history), 32'h0);
        rst = 1'b0;
        step();
        check("first_bubble", 32'(valid), 32'h0);
        step();
        check("first_valid", 32'(valid), 32'h1);
        check("first_pc", pc, 32'h100);
        run(2);
        check("third_pc", pc, 32'h108);

        // backward branch: trained twice, third fetch predicts taken
        for (int k = 0; k < 3; k++) begin
            redirect_to(32'h200, 1'b0, 1'b0, 32'h0, 8'h0);
            run(2);
            if (k == 2) begin
                check("bp_third_pred", 32'(prediction), 32'h1);
                check("bp_target_addr", imem_addr, 32'h1F0);
            end else begin
                resolve_step(1'b1, 8'h80, 32'h200);
            end
        end
        step();
        check("bp_bubble", 32'(valid), 32'h0);
        step();
        check("bp_target_pc", pc, 32'h1F0);

        // mispredict repair and redirect latency
        redirect_to(32'h80, 1'b1, 1'b1, 32'h40, 8'h15);
        check("redir_bubble1", 32'(valid), 32'h0);
        step();
        check("redir_bubble2", 32'(valid), 32'h0);
        step();
        check("redir_valid", 32'(valid), 32'h1);
        check("redir_pc", pc, 32'h80);
        check("redir_pcx", 32'(pc_xor_global_history), GS ? 32'h2B : 32'h20);

        // stall 3 cycles with redirect in the second
        step();
        stall = 1'b1;
        step();
        check("stall_hold_pc", pc, 32'h84);
        check("stall_hold_valid", 32'(valid), 32'h1);
        redirect_to(32'h140, 1'b0, 1'b0, 32'h0, 8'h0);
        check("stall_redir_valid", 32'(valid), 32'h0);
        step();
        stall = 1'b0;
        step();
        step();
        check("stall_redir_pc", pc, 32'h140);

        // JAL
        redirect_to(32'h300, 1'b0, 1'b0, 32'h0, 8'h0);
        run(2);
        check("jal_pred", 32'(prediction), 32'h1);
        check("jal_next_addr", imem_addr, 32'h320);
        step();
        check("jal_bubble", 32'(valid), 32'h0);
        step();
        check("jal_target_pc", pc, 32'h320);

        // counter saturation at index 0x07
        for (int k = 0; k < 5; k++) resolve_step(1'b1, 8'h07, 32'h0);
        resolve_step(1'b0, 8'h07, 32'h0);
        redirect_to(32'h1C, 1'b1, 1'b0, 32'h0, 8'h00);
        run(2);
        check("sat_pc", pc, 32'h1C);
        check("sat_pred", 32'(prediction), GS ? 32'h1 : 32'h0);
        resolve_step(1'b0, 8'h07, 32'h0);
        redirect_to(32'h1C, 1'b1, 1'b0, 32'h0, 8'h00);
        run(2);
        check("sat_dec_pred", 32'(prediction), 32'h0);

        // randomized program and control traffic
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                off = (int'($urandom_range(0, 32)) - 16) * 4;
                prog[i] = enc_b(off);
            end else if (r < 5) begin
                off = (int'($urandom_range(0, 64)) - 32) * 4;
                prog[i] = enc_j(off);
            end else begin
                prog[i] = {$urandom_range(0, 32'hFFF), 1'b0, 12'h0, 7'b0010011} ;
            end
        end
        redirect_to(32'h0, 1'b0, 1'b0, 32'h0, 8'h0);
        for (int n = 0; n < 600; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            redirect      = ($urandom_range(0, 11) == 0);
            redirect_pc   = {22'd0, 8'($urandom), 2'b00};
            resolve_valid = ($urandom_range(0, 2) == 0);
            resolve_taken = 1'($urandom);
            resolve_index = 8'($urandom);
            resolve_pc    = $urandom;
            step();
        end
        stall = 1'b0; redirect = 1'b0; resolve_valid = 1'b0;

        // reset mid-operation
        rst = 1'b1;
        step();
        check("midrst_imem_addr", imem_addr, RST_PC);
        check("midrst_pc", pc, 32'h0);
        rst = 1'b0;
        step();
        check("midrst_bubble", 32'(valid), 32'h0);
        step();
        check("midrst_first_pc", pc, RST_PC);
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
